// File: rtl/leaky_integrate_fire.sv
// +----------------------------------------------------------------------------+
// | leaky_integrate_fire : 8-synapse leaky integrate-and-fire neuron update    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module leaky_integrate_fire #(
  parameter int N_IN   = 8,
  parameter int W      = 8,
  parameter int TREF_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_IN-1:0]     spike_in,
  input  logic [N_IN*W-1:0]   weight,
  input  logic [W-1:0]        memb_potential_in,
  input  logic [W-1:0]        threshold,
  input  logic [W-1:0]        leak_value,
  input  logic [TREF_W-1:0]   tref,
  output logic [W-1:0]        memb_potential_out,
  output logic                spike_out
);

  // Wide enough for the input potential plus every weight at full scale.
  localparam int SUM_W = W + $clog2(N_IN) + 2;
  localparam logic [SUM_W-1:0] C_POT_MAX = {{(SUM_W-W){1'b0}}, {W{1'b1}}};

  logic [SUM_W-1:0]  syn_sum;
  logic [SUM_W-1:0]  pot_sum;
  logic [SUM_W-1:0]  leak_ext;
  logic [SUM_W-1:0]  pot_diff;
  logic [W-1:0]      pot_clamped;

  logic [W-1:0]      memb_d, memb_q;
  logic              spike_d, spike_q;
  logic [TREF_W-1:0] cnt_d, cnt_q;

  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) begin
        syn_sum = syn_sum + {{(SUM_W-W){1'b0}}, weight[W*i +: W]};
      end
    end
  end

  // Subtract the leak only when it cannot go negative, so no wrap is possible.
  always_comb begin
    pot_sum  = {{(SUM_W-W){1'b0}}, memb_potential_in} + syn_sum;
    leak_ext = {{(SUM_W-W){1'b0}}, leak_value};
    pot_diff = pot_sum - leak_ext;
    if (pot_sum <= leak_ext) begin
      pot_clamped = '0;
    end else if (pot_diff > C_POT_MAX) begin
      pot_clamped = {W{1'b1}};
    end else begin
      pot_clamped = pot_diff[W-1:0];
    end
  end

  always_comb begin
    memb_d  = '0;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (pot_clamped >= threshold) begin
      spike_d = 1'b1;
      cnt_d   = tref;
    end else begin
      memb_d  = pot_clamped;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      memb_q  <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      memb_q  <= memb_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  assign memb_potential_out = memb_q;
  assign spike_out          = spike_q;

endmodule

`default_nettype wire

// File: tb/tb_leaky_integrate_fire.sv
// +----------------------------------------------------------------------------+
// | tb_leaky_integrate_fire : bench for the leaky integrate-and-fire neuron    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_leaky_integrate_fire;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  spike_in;
  logic [63:0] weight;
  logic [7:0]  memb_potential_in;
  logic [7:0]  threshold;
  logic [7:0]  leak_value;
  logic [3:0]  tref;
  logic [7:0]  memb_potential_out;
  logic        spike_out;

  int n_assert = 0;
  int n_fail   = 0;

  int wt [8];
  int mdl_ref;
  int exp_pot;
  int exp_spk;

  always #5 clk = ~clk;

  leaky_integrate_fire #(.N_IN(8), .W(8), .TREF_W(4)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .spike_in           (spike_in),
    .weight             (weight),
    .memb_potential_in  (memb_potential_in),
    .threshold          (threshold),
    .leak_value         (leak_value),
    .tref               (tref),
    .memb_potential_out (memb_potential_out),
    .spike_out          (spike_out)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, expv);
    end
  endtask

  task automatic load_weights();
    for (int i = 0; i < 8; i++) weight[8*i +: 8] = 8'(wt[i]);
  endtask

  // Neuron behaviour from the rules: integer sum, clamp, fire or hold off.
  task automatic predict();
    int v;
    if (!reset_n) begin
      exp_pot = 0; exp_spk = 0; mdl_ref = 0;
    end else if (mdl_ref > 0) begin
      exp_pot = 0; exp_spk = 0; mdl_ref = mdl_ref - 1;
    end else begin
      v = int'(memb_potential_in) - int'(leak_value);
      for (int i = 0; i < 8; i++) if (spike_in[i]) v += wt[i];
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
      if (v >= int'(threshold)) begin
        exp_pot = 0; exp_spk = 1; mdl_ref = int'(tref);
      end else begin
        exp_pot = v; exp_spk = 0;
      end
    end
  endtask

  task automatic step(input string tag);
    predict();
    @(posedge clk);
    #1;
    check({tag, ".pot"}, memb_potential_out, 8'(exp_pot));
    check({tag, ".spk"}, {7'd0, spike_out}, 8'(exp_spk));
  endtask

  task automatic cycle(input logic [7:0] m, input logic [7:0] s, input string tag);
    memb_potential_in = m;
    spike_in          = s;
    step(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    step(tag);
    reset_n = 1'b1;
  endtask

  task automatic defaults();
    for (int i = 0; i < 8; i++) wt[i] = i + 1;
    load_weights();
    threshold  = 8'h10;
    leak_value = 8'h01;
    tref       = 4'd2;
  endtask

  initial begin
    reset_n = 1'b0; spike_in = '0; memb_potential_in = '0;
    mdl_ref = 0;
    defaults();
    @(negedge clk);

    // Basic integrate/leak
    do_reset("rst0");
    cycle(8'h00, 8'h01, "s1a");  check("s1a.lit", memb_potential_out, 8'h00);
    cycle(memb_potential_out, 8'h02, "s1b");  check("s1b.lit", memb_potential_out, 8'h01);
    cycle(memb_potential_out, 8'h04, "s1c");  check("s1c.lit", memb_potential_out, 8'h03);

    // Leak floor
    do_reset("rst2");
    cycle(8'h03, 8'h00, "s2");
    for (int k = 0; k < 4; k++) cycle(memb_potential_out, 8'h00, "s2");
    check("s2.floor", memb_potential_out, 8'h00);

    // Fire and refractory, tref change mid-count must not matter
    do_reset("rst3");
    cycle(8'h0A, 8'hE0, "s3fire"); check("s3fire.lit", {7'd0, spike_out}, 8'h01);
    tref = 4'd7;
    cycle(memb_potential_out, 8'hE0, "s3ref1");
    tref = 4'd2;
    cycle(memb_potential_out, 8'hE0, "s3ref2");
    cycle(memb_potential_out, 8'hE0, "s3again"); check("s3again.lit", {7'd0, spike_out}, 8'h01);

    // Threshold edge
    do_reset("rst4");
    cycle(8'h0E, 8'h02, "s4a"); check("s4a.lit", memb_potential_out, 8'h0F);
    cycle(memb_potential_out, 8'h02, "s4b"); check("s4b.lit", {7'd0, spike_out}, 8'h01);

    // Saturation
    do_reset("rst5");
    threshold = 8'hFF;
    cycle(8'hF0, 8'hFF, "s5sat"); check("s5sat.lit", {7'd0, spike_out}, 8'h01);
    do_reset("rst5b");
    cycle(8'h00, 8'hFF, "s5b"); check("s5b.lit", memb_potential_out, 8'h23);
    threshold = 8'h10;

    // Reset mid-refractory
    do_reset("rst6");
    cycle(8'h0A, 8'hE0, "s6fire");
    cycle(memb_potential_out, 8'hE0, "s6ref");
    do_reset("s6rst");
    cycle(8'h00, 8'h80, "s6post"); check("s6post.lit", memb_potential_out, 8'h07);

    // threshold=0 fires every cycle with tref=0
    threshold = 8'h00; tref = 4'd0;
    for (int k = 0; k < 3; k++) cycle(memb_potential_out, 8'h00, "thr0");
    check("thr0.lit", {7'd0, spike_out}, 8'h01);
    defaults();

    // Randomized run with feedback, random weights and occasional resets
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) begin
        for (int i = 0; i < 8; i++) wt[i] = int'($urandom_range(0, 255));
        load_weights();
        threshold  = 8'($urandom_range(0, 255));
        leak_value = 8'($urandom_range(0, 40));
      end
      tref = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) begin
        do_reset("rnd.rst");
      end else begin
        cycle(($urandom_range(0, 9) == 0) ? 8'($urandom) : memb_potential_out,
              8'($urandom), "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
